// File: rtl/guess_game_pkg.sv
// Shared types and constants for the 2-bit number-guessing game controller.
package guess_game_pkg;

    localparam int unsigned GUESS_W = 2;
    localparam int unsigned LFSR_W  = 4;
    localparam int unsigned TAP_HI  = 3;
    localparam int unsigned TAP_LO  = 2;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 4'b1001;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        EVAL,
        WIN,
        LOSE
    } state_e;

    // Comparator outputs {eq, gt, lt} are trusted only when exactly one is set.
    function automatic logic is_one_hot(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage

// File: rtl/guess_game_if.sv
// Player/comparator-facing bundle of the guessing-game controller.
interface guess_game_if
    import guess_game_pkg::*;
#(
    parameter int unsigned TRY_W = 2
) ();

    logic               start;
    logic               guess_valid;
    logic [GUESS_W-1:0] guess;
    logic               cmp_eq;
    logic               cmp_gt;
    logic               cmp_lt;
    logic [GUESS_W-1:0] cmp_a;
    logic [GUESS_W-1:0] cmp_b;
    logic               hint_hi;
    logic               hint_lo;
    logic               win;
    logic               lose;
    logic [TRY_W-1:0]   tries;
    logic               busy;
    logic               cmp_err;

    modport master (
        output start, guess_valid, guess, cmp_eq, cmp_gt, cmp_lt,
        input  cmp_a, cmp_b, hint_hi, hint_lo, win, lose, tries, busy, cmp_err
    );

    modport slave (
        input  start, guess_valid, guess, cmp_eq, cmp_gt, cmp_lt,
        output cmp_a, cmp_b, hint_hi, hint_lo, win, lose, tries, busy, cmp_err
    );

endinterface

// File: rtl/game_lfsr.sv
// Free-running 4-bit Fibonacci LFSR (x^4 + x^3 + 1); supplies the secret.
module game_lfsr
    import guess_game_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [LFSR_W-1:0] lfsr
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    // NOTE: combinational next-state uses blocking '='; only the always_ff
    // below uses '<=', so every register samples pre-edge values.
    always_comb begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[TAP_HI] ^ lfsr_q[TAP_LO]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/guess_game_ctrl.sv
// Guessing-game controller: registers guess/secret for an external 2-bit
// comparator and turns its Eq/Gt/Lt result into win, hint and lose.
module guess_game_ctrl
    import guess_game_pkg::*;
#(
    parameter int unsigned       MAX_TRIES = 3,
    parameter int unsigned       TRY_W     = 2,
    parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED
) (
    input  logic         clk,
    input  logic         rst_n,
    guess_game_if.slave  bus
);

    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

    logic [LFSR_W-1:0]  lfsr;
    logic               lfsr_unused;
    logic               cmp_ok;

    state_e             state_q;
    logic [GUESS_W-1:0] cmp_a_q;
    logic [GUESS_W-1:0] cmp_b_q;
    logic [TRY_W-1:0]   tries_q;
    logic               hint_hi_q;
    logic               hint_lo_q;
    logic               win_q;
    logic               lose_q;
    logic               busy_q;
    logic               cmp_err_q;

    game_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .lfsr  (lfsr)
    );

    // Only the low bits become the secret; the upper bits just keep the sequence long.
    assign lfsr_unused = ^lfsr[LFSR_W-1:GUESS_W];
    assign cmp_ok      = is_one_hot({bus.cmp_eq, bus.cmp_gt, bus.cmp_lt});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmp_a_q   <= '0;
            cmp_b_q   <= '0;
            tries_q   <= '0;
            hint_hi_q <= 1'b0;
            hint_lo_q <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            busy_q    <= 1'b0;
            cmp_err_q <= 1'b0;
        end else if (bus.start && (state_q != EVAL)) begin
            // Restart from any non-EVAL state; beats a same-cycle guess in ARMED.
            cmp_b_q   <= lfsr[GUESS_W-1:0];
            tries_q   <= '0;
            hint_hi_q <= 1'b0;
            hint_lo_q <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ARMED;
        end else begin
            case (state_q)
                ARMED: begin
                    if (bus.guess_valid) begin
                        cmp_a_q <= bus.guess;
                        tries_q <= tries_q + 1'b1;
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    if (!cmp_ok) begin
                        cmp_err_q <= 1'b1;
                    end
                    if (cmp_ok && bus.cmp_eq) begin
                        win_q     <= 1'b1;
                        hint_hi_q <= 1'b0;
                        hint_lo_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= WIN;
                    end else begin
                        // A faulty comparator result counts as a miss but leaves hints alone.
                        if (cmp_ok) begin
                            hint_hi_q <= bus.cmp_gt;
                            hint_lo_q <= bus.cmp_lt;
                        end
                        if (tries_q == TRY_LIMIT) begin
                            lose_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= LOSE;
                        end else begin
                            state_q <= ARMED;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cmp_a   = cmp_a_q;
    assign bus.cmp_b   = cmp_b_q;
    assign bus.tries   = tries_q;
    assign bus.hint_hi = hint_hi_q;
    assign bus.hint_lo = hint_lo_q;
    assign bus.win     = win_q;
    assign bus.lose    = lose_q;
    assign bus.busy    = busy_q;
    assign bus.cmp_err = cmp_err_q;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed self-checking bench for guess_game_ctrl with a behavioural comparator.
module tb_guess_game_ctrl;

    logic       clk;
    logic       rst_n;
    logic       fault;
    logic [3:0] m_lfsr;
    logic [1:0] exp_b;
    int         n_vec;
    int         n_miss;

    guess_game_if #(.TRY_W(2)) bus ();

    guess_game_ctrl #(
        .MAX_TRIES (3),
        .TRY_W     (2),
        .SEED      (4'b1001)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // External comparator, with an injectable non-one-hot fault.
    assign bus.cmp_eq = fault ? 1'b0 : (bus.cmp_a == bus.cmp_b);
    assign bus.cmp_gt = fault ? 1'b1 : (bus.cmp_a >  bus.cmp_b);
    assign bus.cmp_lt = fault ? 1'b1 : (bus.cmp_a <  bus.cmp_b);

    // Reference secret source: x^4 + x^3 + 1, shift left, seed 1001.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 4'b1001;
        else        m_lfsr <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".cmp_a"},   bus.cmp_a,   4'h0);
        check({tag, ".cmp_b"},   bus.cmp_b,   4'h0);
        check({tag, ".tries"},   bus.tries,   4'h0);
        check({tag, ".flags"},
              {bus.hint_hi, bus.hint_lo, bus.win, bus.lose}, 4'h0);
        check({tag, ".busy"},    bus.busy,    4'h0);
        check({tag, ".cmp_err"}, bus.cmp_err, 4'h0);
    endtask

    // Ends at a falling edge with reset released, so the next edge is the 1st.
    task automatic do_reset();
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.guess_valid = 1'b0;
        bus.guess       = 2'b00;
        fault           = 1'b0;
        #7;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_game();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Leaves the bench one cycle after guess_valid, i.e. inside EVAL.
    task automatic present_guess(input logic [1:0] g);
        bus.guess_valid = 1'b1;
        bus.guess       = g;
        tick();
        bus.guess_valid = 1'b0;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;

        // Reset state, then win on the first try.
        do_reset();
        check_idle_outputs("rst");
        start_game();
        check("s1.cmp_b", bus.cmp_b, 4'h1);
        check("s1.busy",  bus.busy,  4'h1);
        present_guess(2'b01);
        check("s1.cmp_a_eval", bus.cmp_a, 4'h1);
        check("s1.tries_eval", bus.tries, 4'h1);
        check("s1.busy_eval",  bus.busy,  4'h1);
        check("s1.win_eval",   bus.win,   4'h0);
        tick();
        check("s1.flags", {bus.hint_hi, bus.hint_lo, bus.win, bus.lose}, 4'b0010);
        check("s1.tries", bus.tries, 4'h1);
        check("s1.busy",  bus.busy,  4'h0);

        // Hints then win.
        do_reset();
        start_game();
        present_guess(2'b11);
        tick();
        check("s2.g1.flags", {bus.hint_hi, bus.hint_lo, bus.win, bus.lose}, 4'b1000);
        check("s2.g1.busy",  bus.busy, 4'h1);
        present_guess(2'b00);
        tick();
        check("s2.g2.flags", {bus.hint_hi, bus.hint_lo, bus.win, bus.lose}, 4'b0100);
        check("s2.g2.tries", bus.tries, 4'h2);
        present_guess(2'b01);
        tick();
        check("s2.g3.flags", {bus.hint_hi, bus.hint_lo, bus.win, bus.lose}, 4'b0010);
        check("s2.g3.tries", bus.tries, 4'h3);

        // Lose after MAX_TRIES misses; later guesses are ignored.
        do_reset();
        start_game();
        present_guess(2'b10);
        tick();
        check("s3.g1.lose", bus.lose, 4'h0);
        present_guess(2'b11);
        tick();
        check("s3.g2.lose", bus.lose, 4'h0);
        present_guess(2'b00);
        tick();
        check("s3.flags", {bus.hint_hi, bus.hint_lo, bus.win, bus.lose}, 4'b0101);
        check("s3.tries", bus.tries, 4'h3);
        check("s3.busy",  bus.busy,  4'h0);
        present_guess(2'b01);
        tick();
        check("s3.hold.flags", {bus.hint_hi, bus.hint_lo, bus.win, bus.lose}, 4'b0101);
        check("s3.hold.tries", bus.tries, 4'h3);
        check("s3.hold.cmp_a", bus.cmp_a, 4'h0);

        // Comparator fault: sticky error, game continues, start does not clear it.
        do_reset();
        start_game();
        present_guess(2'b10);
        fault = 1'b1;
        tick();
        fault = 1'b0;
        check("s4.cmp_err", bus.cmp_err, 4'h1);
        check("s4.busy",    bus.busy,    4'h1);
        check("s4.flags", {bus.hint_hi, bus.hint_lo, bus.win, bus.lose}, 4'b0000);
        check("s4.tries",   bus.tries,   4'h1);
        exp_b = m_lfsr[1:0];
        start_game();
        check("s4.restart.cmp_err", bus.cmp_err, 4'h1);
        check("s4.restart.tries",   bus.tries,   4'h0);
        check("s4.restart.cmp_b",   bus.cmp_b,   exp_b);

        // Async reset in the middle of EVAL.
        present_guess(2'b10);
        check("s6.pre.tries", bus.tries, 4'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("s6.rst");
        @(negedge clk);
        rst_n = 1'b1;
        start_game();
        check("s6.cmp_b", bus.cmp_b, 4'h1);
        check("s6.busy",  bus.busy,  4'h1);

        // Collisions: start beats guess_valid in ARMED; guess_valid ignored in EVAL.
        do_reset();
        start_game();
        present_guess(2'b11);
        tick();
        check("s5.pre.hint_hi", bus.hint_hi, 4'h1);
        exp_b           = m_lfsr[1:0];
        bus.start       = 1'b1;
        bus.guess_valid = 1'b1;
        bus.guess       = 2'b00;
        tick();
        bus.start       = 1'b0;
        bus.guess_valid = 1'b0;
        check("s5.tries",   bus.tries,   4'h0);
        check("s5.cmp_a",   bus.cmp_a,   4'h3);
        check("s5.cmp_b",   bus.cmp_b,   exp_b);
        check("s5.hint_hi", bus.hint_hi, 4'h0);
        check("s5.busy",    bus.busy,    4'h1);
        present_guess(exp_b);
        bus.guess_valid = 1'b1;
        bus.guess       = ~exp_b;
        tick();
        bus.guess_valid = 1'b0;
        check("s5.eval.tries", bus.tries, 4'h1);
        check("s5.eval.cmp_a", bus.cmp_a, exp_b);
        check("s5.eval.win",   bus.win,   4'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
